// File: rtl/regs_pkg.sv
// Shared core package: register file geometry and the common types used by
// decode, execute and the register file.
package regs_pkg;
  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regs.sv
// RV32I integer register file: REG_NUM x XLEN, x0 hardwired to zero.
// One write port (execute write-back), two combinational read ports (decode).
// Build option: REGS_BYPASS_EN -- when defined, a same-cycle write to the
// address being read is forwarded to that read port (write-first); when
// undefined, reads return the stored value (read-first) and decode stalls.
module regs #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(REG_NUM)-1:0] rd_addr,
  input  logic [XLEN-1:0]            rd_data,
  input  logic                       rd_wen,
  input  logic [$clog2(REG_NUM)-1:0] rs1_raddr,
  input  logic [$clog2(REG_NUM)-1:0] rs2_raddr,
  output logic [XLEN-1:0]            rs1_rdata,
  output logic [XLEN-1:0]            rs2_rdata
);
  import regs_pkg::*;

  localparam int NPORT = 2;
  localparam int AW    = $clog2(REG_NUM);

  // Entry 0 carries no state; reads of x0 fall through to the zero default.
  logic [REG_NUM-1:1][XLEN-1:0] mem;
  logic [NPORT-1:0][AW-1:0]     raddr;
  logic                         wr_hit;

  assign raddr  = {rs2_raddr, rs1_raddr};
  assign wr_hit = rd_wen && (rd_addr != AW'(REG_ZERO));

  // Array write; reset clears every entry immediately and blocks writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++)
        if (wr_hit && rd_addr == AW'(i)) mem[i] <= rd_data;
    end
  end

  // Two identical read ports: array select, optional forward, reset gate.
  for (genvar p = 0; p < NPORT; p++) begin : g_rp
    logic [XLEN-1:0] rdata;

    // Combinational read for port p.
    always_comb begin
      rdata = '0;
      for (int i = 1; i < REG_NUM; i++)
        if (raddr[p] == AW'(i)) rdata = mem[i];
`ifdef REGS_BYPASS_EN
      if (wr_hit && raddr[p] == rd_addr) rdata = rd_data;
`endif
      // Keeps the forward path quiet while reset is held.
      if (rst) rdata = '0;
    end
  end

  assign rs1_rdata = g_rp[0].rdata;
  assign rs2_rdata = g_rp[1].rdata;
endmodule

// File: tb/tb_regs.sv
// Directed self-checking bench for the register file. Expectations for the
// same-cycle read-after-write case follow the REGS_BYPASS_EN build option.
module tb_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic        rd_wen = 1'b0;
  logic [4:0]  rs1_raddr = '0;
  logic [4:0]  rs2_raddr = '0;
  logic [31:0] rs1_rdata;
  logic [31:0] rs2_rdata;

  int nchk = 0;
  int nfail = 0;

  regs #(.XLEN(32), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen(rd_wen),
    .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // mid-cycle, away from the edge.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    rd_addr = a; rd_data = d; rd_wen = 1'b1;
    @(posedge clk); #1;
    rd_wen = 1'b0;
  endtask

  task automatic test_reset();
    rs1_raddr = 5'd5; rs2_raddr = 5'd1;
    rd_addr = 5'd5; rd_data = 32'hCAFE_0001; rd_wen = 1'b1;
    #2;
    nchk++; if (rs1_rdata !== 32'h0) begin nfail++; $display("FAIL reset_rs1 got=%h exp=%h", rs1_rdata, 32'h0); end
    nchk++; if (rs2_rdata !== 32'h0) begin nfail++; $display("FAIL reset_rs2 got=%h exp=%h", rs2_rdata, 32'h0); end
    @(posedge clk); #1;
    rd_wen = 1'b0;
    rst = 1'b0;
    #2;
    nchk++; if (rs1_rdata !== 32'h0) begin nfail++; $display("FAIL reset_write_ignored got=%h exp=%h", rs1_rdata, 32'h0); end
    write_reg(5'd5, 32'h1234_5678);
    rs2_raddr = 5'd5;
    #2;
    nchk++; if (rs1_rdata !== 32'h1234_5678) begin nfail++; $display("FAIL reset_prewrite got=%h exp=%h", rs1_rdata, 32'h1234_5678); end
    rst = 1'b1;
    #1;
    nchk++; if (rs1_rdata !== 32'h0) begin nfail++; $display("FAIL reset_async_rs1 got=%h exp=%h", rs1_rdata, 32'h0); end
    nchk++; if (rs2_rdata !== 32'h0) begin nfail++; $display("FAIL reset_async_rs2 got=%h exp=%h", rs2_rdata, 32'h0); end
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    nchk++; if (rs1_rdata !== 32'h0) begin nfail++; $display("FAIL reset_x5_rs1 got=%h exp=%h", rs1_rdata, 32'h0); end
    nchk++; if (rs2_rdata !== 32'h0) begin nfail++; $display("FAIL reset_x5_rs2 got=%h exp=%h", rs2_rdata, 32'h0); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    write_reg(5'd1, 32'hDEAD_BEEF);
    rs1_raddr = 5'd1; rs2_raddr = 5'd2;
    #2;
    nchk++; if (rs1_rdata !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL basic_x1 got=%h exp=%h", rs1_rdata, 32'hDEAD_BEEF); end
    nchk++; if (rs2_rdata !== 32'h0) begin nfail++; $display("FAIL basic_x2 got=%h exp=%h", rs2_rdata, 32'h0); end
    rs1_raddr = 5'd2; rs2_raddr = 5'd1;
    #1;
    nchk++; if (rs2_rdata !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL basic_x1_rs2 got=%h exp=%h", rs2_rdata, 32'hDEAD_BEEF); end
    @(posedge clk); #1;
  endtask

  task automatic test_x0();
    rs1_raddr = 5'd0; rs2_raddr = 5'd0;
    rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF; rd_wen = 1'b1;
    #2;
    nchk++; if (rs1_rdata !== 32'h0) begin nfail++; $display("FAIL x0_same_rs1 got=%h exp=%h", rs1_rdata, 32'h0); end
    nchk++; if (rs2_rdata !== 32'h0) begin nfail++; $display("FAIL x0_same_rs2 got=%h exp=%h", rs2_rdata, 32'h0); end
    @(posedge clk); #1;
    rd_wen = 1'b0;
    #2;
    nchk++; if (rs1_rdata !== 32'h0) begin nfail++; $display("FAIL x0_next_rs1 got=%h exp=%h", rs1_rdata, 32'h0); end
    nchk++; if (rs2_rdata !== 32'h0) begin nfail++; $display("FAIL x0_next_rs2 got=%h exp=%h", rs2_rdata, 32'h0); end
    @(posedge clk); #1;
  endtask

  task automatic test_disabled();
    write_reg(5'd7, 32'h0000_0011);
    rd_addr = 5'd7; rd_data = 32'hAAAA_AAAA; rd_wen = 1'b0;
    rs1_raddr = 5'd7; rs2_raddr = 5'd7;
    #2;
    nchk++; if (rs1_rdata !== 32'h11) begin nfail++; $display("FAIL dis_same got=%h exp=%h", rs1_rdata, 32'h11); end
    @(posedge clk); #1;
    nchk++; if (rs1_rdata !== 32'h11) begin nfail++; $display("FAIL dis_rs1 got=%h exp=%h", rs1_rdata, 32'h11); end
    nchk++; if (rs2_rdata !== 32'h11) begin nfail++; $display("FAIL dis_rs2 got=%h exp=%h", rs2_rdata, 32'h11); end
  endtask

  task automatic test_raw();
    logic [31:0] exp_same;
`ifdef REGS_BYPASS_EN
    exp_same = 32'h20;
`else
    exp_same = 32'h10;
`endif
    write_reg(5'd3, 32'h10);
    rs1_raddr = 5'd3; rs2_raddr = 5'd3;
    rd_addr = 5'd3; rd_data = 32'h20; rd_wen = 1'b1;
    #2;
    nchk++; if (rs1_rdata !== exp_same) begin nfail++; $display("FAIL raw_same_rs1 got=%h exp=%h", rs1_rdata, exp_same); end
    nchk++; if (rs2_rdata !== exp_same) begin nfail++; $display("FAIL raw_same_rs2 got=%h exp=%h", rs2_rdata, exp_same); end
    @(posedge clk); #1;
    rd_wen = 1'b0;
    #2;
    nchk++; if (rs1_rdata !== 32'h20) begin nfail++; $display("FAIL raw_next_rs1 got=%h exp=%h", rs1_rdata, 32'h20); end
    nchk++; if (rs2_rdata !== 32'h20) begin nfail++; $display("FAIL raw_next_rs2 got=%h exp=%h", rs2_rdata, 32'h20); end
    // A write to a different address must not disturb a read of x3.
    rs1_raddr = 5'd3; rd_addr = 5'd4; rd_data = 32'h55; rd_wen = 1'b1;
    #1;
    nchk++; if (rs1_rdata !== 32'h20) begin nfail++; $display("FAIL raw_other_addr got=%h exp=%h", rs1_rdata, 32'h20); end
    @(posedge clk); #1;
    rd_wen = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] e1, e2;
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 32; i++) begin
      rs1_raddr = 5'(i); rs2_raddr = 5'(31 - i);
      e1 = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
      e2 = (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i);
      #1;
      nchk++; if (rs1_rdata !== e1) begin nfail++; $display("FAIL sweep_rs1[%0d] got=%h exp=%h", i, rs1_rdata, e1); end
      nchk++; if (rs2_rdata !== e2) begin nfail++; $display("FAIL sweep_rs2[%0d] got=%h exp=%h", 31 - i, rs2_rdata, e2); end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_basic();
    test_x0();
    test_disabled();
    test_raw();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
